// File: rtl/cont_bcd_if.sv
// Command/status bundle between front-panel logic and the decade-counter run controller.
interface cont_bcd_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic [4*DIGITS-1:0]   target;
  logic [4*DIGITS-1:0]   count;
  logic                  run;
  logic                  done;
  logic                  wrap;
  logic                  err;

  modport master (
    output start, stop, clear, target,
    input  count, run, done, wrap, err
  );

  modport slave (
    input  start, stop, clear, target,
    output count, run, done, wrap, err
  );
endinterface

// File: rtl/cont_bcd_ctrl.sv
// Run controller for a cascade of BCD decade digits: start/stop/clear sequencing,
// prescaled counting and automatic stop on a programmed target.
module cont_bcd_ctrl #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned PRESC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  cont_bcd_if.slave  bus
);
  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, tgt_q, tgt_d, cnt_inc;
  logic [PW-1:0] psc_q, psc_d;
  logic          wrap_q, wrap_d, err_q, err_d;
  logic          tick, tgt_ok, all_nine;

  assign tick = (state_q == StRun) && (psc_q == PLAST);

  // Digit i advances only while every lower digit sits at 9.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    cnt_inc = cnt_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        cnt_inc[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
      end
      carry = carry & (cnt_q[4*i +: 4] == 4'd9);
    end
    all_nine = carry;
  end

  always_comb begin
    tgt_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.target[4*i +: 4] > 4'd9) tgt_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    psc_d   = psc_q;
    tgt_d   = tgt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      psc_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start && !bus.stop) begin
            if (tgt_ok) begin
              tgt_d   = bus.target;
              cnt_d   = '0;
              psc_d   = '0;
              state_d = StRun;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StRun: begin
          psc_d = tick ? '0 : psc_q + 1'b1;
          if (tick) begin
            cnt_d  = cnt_inc;
            wrap_d = all_nine;
            if ((tgt_q != '0) && (cnt_inc == tgt_q)) state_d = StDone;
          end
          // A stop on the matching tick wins: pause holding the incremented count.
          if (bus.stop) state_d = StPause;
        end
        StPause: begin
          if (bus.start && !bus.stop) state_d = StRun;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      psc_q   <= '0;
      tgt_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
      tgt_q   <= tgt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.count = cnt_q;
  assign bus.run   = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_cont_bcd_ctrl.sv
// Bench for cont_bcd_ctrl: PRESC=1 and PRESC=3 instances share stimulus and are
// checked against an integer-count reference model plus directed sequences.
module tb_cont_bcd_ctrl;
  localparam int unsigned DIGITS = 2;
  localparam int MOD = 100;
  localparam int MIDLE = 0, MRUN = 1, MPAUSE = 2, MDONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [7:0] target = 8'h00;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  cont_bcd_if #(.DIGITS(DIGITS)) b1 ();
  cont_bcd_if #(.DIGITS(DIGITS)) b3 ();

  assign b1.start  = start;
  assign b1.stop   = stop;
  assign b1.clear  = clear;
  assign b1.target = target;
  assign b3.start  = start;
  assign b3.stop   = stop;
  assign b3.clear  = clear;
  assign b3.target = target;

  cont_bcd_ctrl #(.DIGITS(DIGITS), .PRESC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  cont_bcd_ctrl #(.DIGITS(DIGITS), .PRESC(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct packed {
    int st;
    int cnt;
    int psc;
    int tgt;
    bit wrap;
    bit err;
  } mstate_t;

  localparam mstate_t M_RST = '{st: MIDLE, cnt: 0, psc: 0, tgt: 0, wrap: 1'b0, err: 1'b0};

  mstate_t m1 = M_RST;
  mstate_t m3 = M_RST;

  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit bcd_ok(logic [7:0] t);
    return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd9);
  endfunction

  function automatic int from_bcd(logic [7:0] t);
    return int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  // Reference: count kept as a plain integer modulo 10^DIGITS.
  function automatic mstate_t step(mstate_t m, int p, logic s, logic sp, logic c,
                                   logic [7:0] t);
    mstate_t n = m;
    n.wrap = 1'b0;
    n.err  = 1'b0;
    if (c) begin
      n.st = MIDLE; n.cnt = 0; n.psc = 0;
    end else if (m.st == MIDLE || m.st == MDONE) begin
      if (s && !sp) begin
        if (bcd_ok(t)) begin
          n.tgt = from_bcd(t); n.cnt = 0; n.psc = 0; n.st = MRUN;
        end else begin
          n.err = 1'b1;
        end
      end
    end else if (m.st == MRUN) begin
      if (m.psc == p - 1) begin
        n.psc  = 0;
        n.cnt  = (m.cnt + 1) % MOD;
        n.wrap = (n.cnt == 0);
        if (m.tgt != 0 && n.cnt == m.tgt) n.st = MDONE;
      end else begin
        n.psc = m.psc + 1;
      end
      if (sp) n.st = MPAUSE;
    end else if (s && !sp) begin
      n.st = MRUN;
    end
    return n;
  endfunction

  function automatic logic [11:0] exp_out(mstate_t m);
    return {to_bcd(m.cnt), m.st == MRUN, m.st == MDONE, m.wrap, m.err};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= M_RST;
      m3 <= M_RST;
    end else begin
      m1 <= step(m1, 1, start, stop, clear, target);
      m3 <= step(m3, 3, start, stop, clear, target);
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model_p1", 32'({b1.count, b1.run, b1.done, b1.wrap, b1.err}), 32'(exp_out(m1)));
      chk("model_p3", 32'({b3.count, b3.run, b3.done, b3.wrap, b3.err}), 32'(exp_out(m3)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmd(logic s, logic sp, logic c, logic [7:0] t);
    start = s; stop = sp; clear = c; target = t;
  endtask

  typedef struct {
    logic       s, sp, c;
    logic [7:0] t;
    logic [7:0] cnt;
    logic       run, done, err;
  } vec_t;

  vec_t tbl[16];
  int   n;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h1A, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h1A, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h1A, 8'h01, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0};

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    chk("reset_p1", 32'({b1.count, b1.run, b1.done, b1.wrap, b1.err}), 32'h0);
    chk("reset_p3", 32'({b3.count, b3.run, b3.done, b3.wrap, b3.err}), 32'h0);
    @(negedge clk);
    chk_en = 1'b1;

    // Table vectors against the PRESC=1 instance
    for (int i = 0; i < 16; i++) begin
      cmd(tbl[i].s, tbl[i].sp, tbl[i].c, tbl[i].t);
      cyc();
      chk($sformatf("vec%0d", i), 32'({b1.count, b1.run, b1.done, b1.err}),
          32'({tbl[i].cnt, tbl[i].run, tbl[i].done, tbl[i].err}));
    end
    cmd(1'b0, 1'b0, 1'b0, 8'h00);

    // Count to 0x25 with carry, then hold in DONE
    cmd(1'b0, 1'b0, 1'b1, 8'h00); cyc();
    cmd(1'b1, 1'b0, 1'b0, 8'h25); cyc();
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t25_run", 32'(b1.run), 32'd1);
    for (int k = 1; k <= 25; k++) begin
      cyc();
      chk($sformatf("t25_cnt%0d", k), 32'(b1.count), 32'(to_bcd(k)));
    end
    chk("t25_done", 32'({b1.run, b1.done}), 32'b01);
    repeat (10) cyc();
    chk("t25_hold", 32'({b1.count, b1.done}), 32'({8'h25, 1'b1}));

    // PRESC=3, target 4: done 12 cycles after run rises
    cmd(1'b0, 1'b0, 1'b1, 8'h00); cyc();
    cmd(1'b1, 1'b0, 1'b0, 8'h04); cyc();
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    chk("p3_run", 32'(b3.run), 32'd1);
    n = 0;
    while (!b3.done && n < 100) begin
      cyc();
      n++;
    end
    chk("p3_done_latency", 32'(n), 32'd12);
    chk("p3_done_cnt", 32'(b3.count), 32'h04);

    // Free-run wrap after 100 ticks
    cmd(1'b0, 1'b0, 1'b1, 8'h00); cyc();
    cmd(1'b1, 1'b0, 1'b0, 8'h00); cyc();
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 101; k++) begin
      cyc();
      if (k == 99) chk("fr_99", 32'({b1.count, b1.wrap}), 32'({8'h99, 1'b0}));
      if (k == 100) chk("fr_wrap", 32'({b1.count, b1.wrap, b1.done}), 32'({8'h00, 2'b10}));
      if (k == 101) chk("fr_wrap_end", 32'({b1.count, b1.wrap}), 32'({8'h01, 1'b0}));
    end

    // Pause at 0x07, hold, resume to target 0x12
    cmd(1'b0, 1'b0, 1'b1, 8'h00); cyc();
    cmd(1'b1, 1'b0, 1'b0, 8'h12); cyc();
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (6) cyc();
    cmd(1'b0, 1'b1, 1'b0, 8'h00); cyc();
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    chk("pause_cnt", 32'({b1.count, b1.run}), 32'({8'h07, 1'b0}));
    repeat (20) cyc();
    chk("pause_hold", 32'({b1.count, b1.run, b1.done}), 32'({8'h07, 2'b00}));
    cmd(1'b1, 1'b0, 1'b0, 8'h00); cyc();
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (5) cyc();
    chk("resume_done", 32'({b1.count, b1.done}), 32'({8'h12, 1'b1}));

    // Async reset mid-count at 0x33
    cmd(1'b0, 1'b0, 1'b1, 8'h00); cyc();
    cmd(1'b1, 1'b0, 1'b0, 8'h00); cyc();
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    n = 0;
    while (b1.count != 8'h33 && n < 200) begin
      cyc();
      n++;
    end
    chk("ar_reach33", 32'(b1.count), 32'h33);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_p1", 32'({b1.count, b1.run, b1.done, b1.wrap, b1.err}), 32'h0);
    chk("ar_p3", 32'({b3.count, b3.run, b3.done, b3.wrap, b3.err}), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    cmd(1'b1, 1'b0, 1'b0, 8'h00); cyc();
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ar_restart0", 32'({b1.count, b1.run}), 32'({8'h00, 1'b1}));
    cyc();
    chk("ar_restart1", 32'(b1.count), 32'h01);

    // Random commands, checked every cycle against the model
    for (int k = 0; k < 3000; k++) begin
      clear  = ($urandom_range(0, 99) < 2);
      stop   = ($urandom_range(0, 99) < 5);
      start  = ($urandom_range(0, 99) < 10);
      target = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                           : to_bcd($urandom_range(0, 20));
      cyc();
    end
    cmd(1'b0, 1'b0, 1'b0, 8'h00);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cont_bcd_ctrl.md
Name: cont_bcd_ctrl

Overview:
Run controller for a cascade of DIGITS synchronous decade counters, each counting 0..9 with synchronous carry. It sequences counting with start/stop/clear commands and a programmable prescaler, and stops automatically on a programmed BCD target. It sits between the front-panel command logic and the display/decoder path. It is the sequencing layer over the decade-counter datapath.

Parameters:
DIGITS, 2, number of cascaded decade digits (1..4); digit 0 is least significant.
PRESC, 1, count advances once every PRESC cycles spent in RUN (1..1024).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle command: capture target, begin/resume counting
stop  input  1  single-cycle command: pause counting
clear  input  1  single-cycle command: zero count, return to IDLE
target  input  4*DIGITS  BCD stop value, nibble i = digit i; 0 = free-run
count  output  4*DIGITS  current BCD count, nibble i = digit i
run  output  1  high while in RUN
done  output  1  high while in DONE
wrap  output  1  one-cycle pulse when count rolls from all-9s to 0
err  output  1  one-cycle pulse when start is rejected for invalid target

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, prescaler=0, target register=0, run=0, done=0, wrap=0, err=0.
- States: IDLE, RUN, PAUSE, DONE. run=(state==RUN), done=(state==DONE); both registered from state.
- Command priority in the same cycle: clear > stop > start.
- clear in any state -> IDLE next cycle, count=0, prescaler=0.
- IDLE + start:
  - If any target nibble >9: stay IDLE, err=1 for one cycle, target register unchanged.
  - Otherwise: capture target, prescaler=0, count=0, go to RUN.
- RUN + stop -> PAUSE; count and prescaler hold.
- PAUSE + start -> RUN; target is NOT re-captured, prescaler resumes from its held value.
- DONE + start: validated as in IDLE; if valid, count=0, prescaler=0, new target captured, go to RUN.
- stop in IDLE/PAUSE/DONE is ignored. start in RUN is ignored.
- Prescaler: in RUN it counts 0..PRESC-1. tick=1 in the cycle where prescaler==PRESC-1, after which the prescaler wraps to 0. With PRESC=1, tick=1 on every RUN cycle.
- Counting on tick:
  - Digit 0 increments.
  - Digit i (i>0) increments only when all lower digits ==9.
  - A digit at 9 that increments becomes 0.
  - Digits never hold values >9.
- wrap=1 in the cycle after the tick that takes count from all-9s to 0.
- Target match: when the post-increment count equals a non-zero target, the next state is DONE and count holds at target. In DONE there are no further ticks and the prescaler holds.
- Target 0 = free-run: never enters DONE and wraps indefinitely.
- Latency (PRESC=1): start sampled at edge t -> run=1 after edge t. First tick occurs in the cycle after edge t, so count=1 after edge t+1. done=1 after the edge at which count reaches target.
- A stop asserted in the same cycle as a matching tick: stop wins. Go to PAUSE with the incremented count; the next start resumes, and DONE is only re-evaluated on a later tick.
- rst asserted mid-count: immediate return to reset values regardless of clk.
- Outputs count/run/done/wrap/err are all registered; no combinational path from inputs to outputs.

Test Plan:
- DIGITS=2, PRESC=1: reset, start with target=0x25 -> count 0x01,0x02..0x09,0x10 (carry at 9) ... 0x25 at cycle 25 after start; done=1, run=0, count holds 0x25 for 10 further cycles.
- DIGITS=2, PRESC=3, target=0x04: start -> count increments every 3rd cycle; done asserts 12 cycles after run rises.
- Free-run: target=0x00, PRESC=1 -> count 0x99 then 0x00 with wrap=1 for exactly one cycle, 100 cycles after start; done stays 0.
- Pause/resume: stop at count=0x07, idle 20 cycles -> count stays 0x07. start -> counting resumes, reaches target 0x12 after 5 more ticks. Mid-prescale resume with PRESC=3 keeps the partial phase.
- Priority and rejection:
  - clear+stop+start in the same cycle -> IDLE, count=0.
  - start with target=0x1A -> err=1 for one cycle, stays IDLE.
  - stop on the matching tick -> PAUSE, not DONE.
- Async reset: assert rst between clock edges while in RUN at count=0x33 -> all outputs zero immediately. Deassert, then start -> counting restarts from 0.
